// File: rtl/fifo_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bist_pkg
// Description : Shared types, traffic-mode encodings and LFSR step function
//               for the FIFO built-in self-test engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } bist_state_t;

  localparam logic [1:0] c_mode_fill_drain = 2'd0;
  localparam logic [1:0] c_mode_stream     = 2'd1;
  localparam logic [1:0] c_mode_throttle   = 2'd2;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] c_lfsr_poly = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? c_lfsr_poly : 32'h0000_0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_bist_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bist_checker_if
// Description : FIFO write/read port bundle seen by the BIST engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_bist_checker_if #(
  parameter int DATA_SIZE = 8
);
  logic                 wr_en;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 full;
  logic                 rd_en;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 empty;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, empty, rd_data
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, empty, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : bist_lfsr
// Description : 32-bit Galois LFSR with seed reload; exposes the low data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr
  import fifo_bist_pkg::*;
#(
  parameter int          DATA_SIZE = 8,
  parameter logic [31:0] SEED      = 32'h0000_00A5
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 load,
  input  wire logic                 advance,
  output logic      [DATA_SIZE-1:0] value
);

  logic [31:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= SEED;
    end else if (advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign value = r_state[DATA_SIZE-1:0];

endmodule
`default_nettype wire

// File: rtl/fifo_bist_checker.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bist_checker
// Description : LFSR-driven FIFO self-test: writes a pseudo-random sequence,
//               regenerates it on the read side and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_bist_checker
  import fifo_bist_pkg::*;
#(
  parameter int          DATA_SIZE = 8,
  parameter int          ADDR_SIZE = 4,
  parameter int          NUM_WORDS = 64,
  parameter logic [31:0] SEED      = 32'h0000_00A5,
  parameter int          TIMEOUT   = 256,
  parameter int          CNT_W     = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   start,
  input  wire logic                   abort,
  input  wire logic [1:0]             mode,
  fifo_bist_checker_if.master         fifo,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic      [CNT_W-1:0]       err_cnt,
  output logic      [CNT_W-1:0]       first_err_idx,
  output logic      [DATA_SIZE-1:0]   first_err_exp,
  output logic      [DATA_SIZE-1:0]   first_err_got
);

  localparam int               c_idle_w    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_num_words = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] c_depth     = CNT_W'(2 ** ADDR_SIZE);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT - 1);

  bist_state_t          r_state;
  logic [1:0]           r_mode;
  logic                 r_phase;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic [CNT_W-1:0]     r_cmp_idx;
  logic                 r_rd_pend;
  logic [c_idle_w-1:0]  r_idle_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;
  logic [CNT_W-1:0]     r_err_cnt;
  logic [CNT_W-1:0]     r_first_idx;
  logic [DATA_SIZE-1:0] r_first_exp;
  logic [DATA_SIZE-1:0] r_first_got;

  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_start;
  logic                 w_active;
  logic                 w_wd_fire;
  logic                 w_mismatch;
  logic                 w_stream_sel;
  logic [DATA_SIZE-1:0] w_wr_data;
  logic [DATA_SIZE-1:0] w_exp_data;

  always_comb begin
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    if ((r_state == ST_FILL || r_state == ST_STREAM) && !fifo.full
        && r_wr_cnt < c_num_words) begin
      w_wr_en = 1'b1;
    end
    if (r_state == ST_DRAIN && !fifo.empty && r_rd_cnt < r_wr_cnt) begin
      w_rd_en = 1'b1;
    end
    if (r_state == ST_STREAM && !fifo.empty && r_rd_cnt < r_wr_cnt
        && r_rd_cnt < c_num_words && (r_mode != c_mode_throttle || r_phase)) begin
      w_rd_en = 1'b1;
    end
  end

  assign w_start      = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_active     = (r_state == ST_FILL) || (r_state == ST_DRAIN) || (r_state == ST_STREAM);
  assign w_wd_fire    = w_active && !w_wr_en && !w_rd_en && (r_idle_cnt == c_idle_last);
  assign w_mismatch   = r_rd_pend && (fifo.rd_data != w_exp_data);
  assign w_stream_sel = (mode == c_mode_stream) || (mode == c_mode_throttle);

  bist_lfsr #(.DATA_SIZE(DATA_SIZE), .SEED(SEED)) u_wr_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_start),
    .advance (w_wr_en),
    .value   (w_wr_data)
  );

  bist_lfsr #(.DATA_SIZE(DATA_SIZE), .SEED(SEED)) u_exp_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_start),
    .advance (r_rd_pend),
    .value   (w_exp_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= c_mode_fill_drain;
      r_phase     <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_cmp_idx   <= '0;
      r_rd_pend   <= 1'b0;
      r_idle_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      // Read data arrives one cycle after rd_en, so compare against the index latched then
      r_rd_pend <= w_rd_en;
      r_cmp_idx <= r_rd_cnt;
      r_phase   <= ~r_phase;
      if (w_mismatch) begin
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
        if (r_err_cnt == '0) begin
          r_first_idx <= r_cmp_idx;
          r_first_exp <= w_exp_data;
          r_first_got <= fifo.rd_data;
        end
      end
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
      if (w_wr_en || w_rd_en) begin
        r_idle_cnt <= '0;
      end else if (w_active) begin
        r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
      end

      case (r_state)
        ST_FILL: begin
          if (r_wr_cnt == c_num_words || (r_wr_cnt - r_rd_cnt) == c_depth) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_rd_cnt == c_num_words) begin
            r_state <= ST_FLUSH;
          end else if (r_rd_cnt == r_wr_cnt && r_wr_cnt < c_num_words) begin
            r_state <= ST_FILL;
          end
        end
        ST_STREAM: begin
          if (r_rd_cnt == c_num_words) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == '0) && !w_mismatch && !r_timeout;
        end
        default: begin
        end
      endcase

      if (w_wd_fire) begin
        r_state   <= ST_DONE;
        r_timeout <= 1'b1;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_pass    <= 1'b0;
      end

      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
      end

      if (w_start) begin
        r_state     <= w_stream_sel ? ST_STREAM : ST_FILL;
        r_mode      <= mode;
        r_phase     <= 1'b0;
        r_wr_cnt    <= '0;
        r_rd_cnt    <= '0;
        r_rd_pend   <= 1'b0;
        r_idle_cnt  <= '0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_timeout   <= 1'b0;
        r_err_cnt   <= '0;
        r_first_idx <= '0;
        r_first_exp <= '0;
        r_first_got <= '0;
      end
    end
  end

  assign fifo.wr_en   = w_wr_en;
  assign fifo.rd_en   = w_rd_en;
  assign fifo.wr_data = w_wr_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign first_err_exp = r_first_exp;
  assign first_err_got = r_first_got;

endmodule
`default_nettype wire

// File: doc/fifo_bist_checker.md
# fifo_bist_checker

Synthesisable, parametrised built-in self-test engine for the FIFO family. It drives a FIFO's write port with LFSR-generated data and regenerates the same sequence to check the read port. It counts mismatches and captures the first failure. It sits beside any FIFO instance on a single clock, replacing simulation-only checking with silicon-usable pass/fail, and adds selectable traffic modes and a watchdog.

## Interface
- DATA_SIZE, 8: FIFO data width, 1..32.
- ADDR_SIZE, 4: FIFO address width; DEPTH = 2**ADDR_SIZE.
- NUM_WORDS, 64: words written and read per run, ≥1.
- SEED, 32'h0000_00A5: LFSR seed, nonzero.
- TIMEOUT, 256: idle cycles before watchdog fires.
- CNT_W, 16: width of word/error counters.

Ports:
- clk  in  1  single clock; FIFO wr and rd sides both run on it.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- abort  in  1  synchronous; returns to IDLE; done is not raised.
- mode  in  2  0 fill-then-drain, 1 streaming, 2 throttled streaming, 3 treated as 0.
- wr_en  out  1  FIFO write enable.
- wr_data  out  DATA_SIZE  FIFO write data.
- full  in  1  FIFO full flag.
- rd_en  out  1  FIFO read enable.
- rd_data  in  DATA_SIZE  FIFO read data, valid the cycle after rd_en.
- empty  in  1  FIFO empty flag.
- busy  out  1  run in progress.
- done  out  1  run finished; held until start or abort.
- pass  out  1  done & err_cnt==0 & !timeout.
- timeout  out  1  watchdog fired.
- err_cnt  out  CNT_W  mismatches; saturates at all ones.
- first_err_idx  out  CNT_W  read index of first mismatch.
- first_err_exp, first_err_got  out  DATA_SIZE  expected and received data at the first mismatch.

## Operation
- States: IDLE, FILL, DRAIN, STREAM, FLUSH, DONE.
- start in IDLE or DONE:
  - reload both LFSRs with SEED.
  - clear wr_cnt, rd_cnt, err_cnt, first_err_*, timeout and the idle counter.
  - go to FILL if mode is 0 or 3; go to STREAM if mode is 1 or 2.
- wr_en = (FILL|STREAM) & !full & wr_cnt<NUM_WORDS.
  - An accepted write advances the write LFSR and increments wr_cnt.
- rd_en:
  - DRAIN: !empty & rd_cnt<wr_cnt.
  - STREAM: additionally rd_cnt<NUM_WORDS; in mode 2 also gated by a phase bit that toggles every cycle.
- FILL → DRAIN when wr_cnt==NUM_WORDS or (wr_cnt−rd_cnt)==DEPTH.
- DRAIN:
  - → FILL when rd_cnt==wr_cnt and wr_cnt<NUM_WORDS.
  - → FLUSH when rd_cnt==NUM_WORDS.
- STREAM → FLUSH when rd_cnt==NUM_WORDS.
- FLUSH lasts one cycle, covering the last compare, then goes to DONE.
- Compare: one cycle after an accepted read, rd_data is compared with the expected LFSR value; the expected LFSR then advances.
  - On mismatch err_cnt increments, saturating.
  - The first_err_* fields load only when err_cnt was 0.
- Watchdog:
  - Increments in FILL, DRAIN and STREAM on cycles with neither wr_en nor rd_en.
  - Clears on any transfer.
  - At TIMEOUT it sets timeout and goes to DONE.
- abort in any state goes to IDLE; counters and capture fields are kept.
- start while busy is ignored.

## Timing
- Reset values:
  - IDLE, wr_en=0, rd_en=0, wr_data=SEED[DATA_SIZE-1:0].
  - busy=0, done=0, pass=0, timeout=0.
  - err_cnt=0, first_err_*=0.
- wr_en and rd_en are combinational from registered state and the full/empty inputs. Every other output is registered.
- start to first wr_en: 1 cycle, since the state registers on the start edge.
- Last read to done=1: 2 cycles (compare, then FLUSH).
- LFSR is a 32-bit Galois with polynomial x^32+x^22+x^2+x+1; data is the low DATA_SIZE bits.
- Counter compares are unsigned at CNT_W bits, and NUM_WORDS must be less than 2**CNT_W.

## Structure
- The package fifo_bist_pkg holds:
  - the state enum.
  - the mode encodings.
  - the LFSR polynomial constant.
  - the function that computes the next LFSR value.
- One sub-module, bist_lfsr (load, advance, value), is instantiated twice: once for write data and once for expected data.

## Test plan
- Mode 0, ideal 16-deep sync FIFO, defaults → 4 fill/drain rounds; done within 200 cycles; pass=1, err_cnt=0.
- Mode 1 → 64 words matched; wr_en high on the first 16 consecutive cycles; pass=1.
- Mode 2 → rd_en is never high two consecutive cycles; pass=1.
- Mode 1 with rd_data bit 0 flipped on read index 5 → err_cnt=1, first_err_idx=5, first_err_got = first_err_exp ^ 1, pass=0.
- full stuck at 1 → after 256 idle cycles timeout=1, done=1, pass=0.
- rst_n asserted mid-STREAM → all outputs return to reset values at once; a subsequent start completes with pass=1.
